// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR tap accumulate stage.
package fir_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_TAP_NUM    = 8;
  localparam int DEFAULT_ACC_WIDTH  = 19;

  localparam logic signed [DEFAULT_DATA_WIDTH-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [DEFAULT_DATA_WIDTH-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1
  } state_t;

endpackage

// File: rtl/fir_sat_trunc.sv
// Combinational saturating narrow from the accumulator width to the sample width.
module fir_sat_trunc
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  clip
);

  // The value fits only if every bit above the output sign bit equals that sign bit.
  logic [ACC_WIDTH-DATA_WIDTH:0] upper;

  assign upper = acc[ACC_WIDTH-1:DATA_WIDTH-1];

  always_comb begin
    clip = !((&upper) || !(|upper));
    data = acc[DATA_WIDTH-1:0];
    if (clip) begin
      data = acc[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_tap_accumulator.sv
// Accumulates TAP_NUM signed tap partial sums per group and emits one saturated
// sample per group over a valid/ready handshake, flagging clipping and length errors.
module fir_tap_accumulator
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TAP_NUM    = DEFAULT_TAP_NUM,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sat,
  output logic                  err_len
);

  localparam int CNT_WIDTH = $clog2(TAP_NUM + 1);

  state_t state, state_next;

  logic [ACC_WIDTH-1:0]  acc, acc_next, beat_ext;
  logic [CNT_WIDTH-1:0]  cnt, cnt_inc, cnt_next;
  logic                  accept, at_tap_num, closing, len_mismatch;
  logic [DATA_WIDTH-1:0] sat_data;
  logic                  sat_clip;

  // Stall input whenever a finished sample is waiting for the consumer.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign beat_ext = {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign cnt_inc  = cnt + 1'b1;

  always_comb begin
    state_next   = state;
    acc_next     = acc;
    cnt_next     = cnt;
    at_tap_num   = 1'b0;
    closing      = 1'b0;
    len_mismatch = 1'b0;
    if (accept) begin
      acc_next     = (state == IDLE) ? beat_ext : acc + beat_ext;
      at_tap_num   = (cnt_inc == CNT_WIDTH'(TAP_NUM));
      closing      = in_last || at_tap_num;
      len_mismatch = in_last != at_tap_num;
      cnt_next     = closing ? '0 : cnt_inc;
      state_next   = closing ? IDLE : ACC;
    end
  end

  // The saturator sees the post-add sum so the closing beat lands in the same edge.
  fir_sat_trunc #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat (
    .acc (acc_next),
    .data(sat_data),
    .clip(sat_clip)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      acc     <= acc_next;
      cnt     <= cnt_next;
      err_len <= closing && len_mismatch;
      if (closing) begin
        out_valid <= 1'b1;
        out_data  <= sat_data;
        out_sat   <= sat_clip;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fir_tap_accumulator.md
Name: fir_tap_accumulator

Overview:
Sequential accumulate stage directly downstream of the FIR ripple-carry adder. It takes a stream of signed 16-bit tap partial sums, one per accepted beat, and accumulates TAP_NUM beats per output sample in a widened accumulator. It then emits one saturated 16-bit filter output per group over a valid/ready handshake. The block also flags saturation and group-length errors.

Parameters:
DATA_WIDTH, 16, width of input beats and output sample (two's complement)
TAP_NUM, 8, beats per output group (>=2)
ACC_WIDTH, 19, accumulator width; must be >= DATA_WIDTH + clog2(TAP_NUM)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_data  in  DATA_WIDTH  signed tap partial sum
in_valid  in  1  in_data valid
in_last  in  1  marks final beat of a group
in_ready  out  1  block can accept a beat this cycle
out_data  out  DATA_WIDTH  saturated signed group sum
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
out_sat  out  1  out_data was clipped; valid with out_valid
err_len  out  1  one-cycle pulse on a group-length mismatch

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_sat=0, err_len=0. in_ready=0 while rst is high. Any partial group is discarded.
- in_ready = !rst && (!out_valid || out_ready). A beat is accepted when in_valid && in_ready.
- States:
  - IDLE: waiting for the first beat. On accept: acc <= sext(in_data), cnt <= 1, go to ACC. If in_last is set on this beat, close the group immediately.
  - ACC: on accept: acc <= acc + sext(in_data) (ACC_WIDTH-bit add, no wrap possible by sizing), cnt <= cnt+1.
  - A group closes on the accepted beat where in_last=1 OR cnt reaches TAP_NUM (i.e. the TAP_NUM-th beat).
  - Closing rules:
    - err_len=1 for exactly the next cycle if in_last disagrees with the count (early in_last, or TAP_NUM-th beat without in_last).
    - The group still closes and its output is still produced.
    - out_valid <= 1, out_data <= sat(final acc), out_sat <= clip flag. State returns to IDLE.
- Latency: out_valid rises the cycle after the closing beat is accepted.
- out_data/out_sat hold stable while out_valid=1 && out_ready=0. Input is stalled (in_ready=0) during this time.
- Simultaneous events: out_ready=1 with out_valid=1 lets the first beat of the next group be accepted in the same cycle. out_valid then drops unless that beat also closes a group; a one-beat group reloads out_valid=1 with the new result.
- Sustained throughput: one output per TAP_NUM cycles with out_ready tied high.
- Saturation:
  - acc > 2^(DATA_WIDTH-1)-1 gives 32767, out_sat=1.
  - acc < -2^(DATA_WIDTH-1) gives -32768, out_sat=1.
  - Otherwise out_data = acc[DATA_WIDTH-1:0], out_sat=0.
- cnt never exceeds TAP_NUM; it resets to 0 on group close.

Decomposition:
- Shared package/include fir_pkg:
  - DATA_WIDTH, TAP_NUM, ACC_WIDTH defaults
  - SAT_MAX/SAT_MIN constants
  - state encoding IDLE/ACC (2-bit localparams)
- One sub-module, fir_sat_trunc: combinational ACC_WIDTH-to-DATA_WIDTH saturator producing data and the clip flag. The FSM, counter and output register stay in the top module.

Test Plan:
- Basic group: 8 beats of +12 with in_last on beat 8, out_ready=1 -> one cycle later out_valid=1, out_data=96, out_sat=0, err_len=0.
- Positive saturation: 8 beats of 16'd32000 -> out_data=32767, out_sat=1. Negative: 8 beats of -32768 -> out_data=-32768, out_sat=1.
- Back-pressure: group of 1..8 (sum 36), out_ready=0 for 5 cycles -> out_data=36 held, in_ready=0 throughout. Release out_ready while the next group's first beat is valid -> that beat is accepted in the same cycle.
- Length error: in_last on beat 3 with values 5,6,7 -> out_data=18, err_len pulse 1 cycle. 8 beats with no in_last -> output produced plus err_len pulse.
- Reset mid-group: 4 beats of 100, assert rst one cycle, then a full group of 8 x 1 -> out_data=8 (partial sum discarded). All outputs are 0 during reset.
- Streaming: 3 back-to-back groups (all +1, all -1, alternating +/-1) with out_ready=1 -> outputs 8, -8, 0 on consecutive group boundaries with no lost beats.
